uart_tx_periph: RTL and testbench
=================================

// Module: uart_tx_periph
// PURPOSE
//  Memory-mapped UART transmitter on the CPU peripheral bus, downstream of the MIO bus decoder.
//  Consumes the decoder's write strobe and Peripheral_in word and buffers bytes in a FIFO.
//  Serialises each byte 8N1 (8N1+even parity when enabled) on txd.
//  Returns a status word for the decoder's CPU read mux.
// PARAMETERS
//  BAUD_DIV    868  clk cycles per serial bit (100 MHz / 115200); legal >= 2
//  FIFO_AW     4    FIFO address width; depth = 2**FIFO_AW = 16 entries
// PORTS
//  clk         in   1   system clock (clk_100mhz domain)
//  RSTN        in   1   asynchronous active-low reset
//  uart_we     in   1   one-cycle write strobe from bus decoder
//  uart_data   in   32  write data (Peripheral_in); [7:0] byte, [8] control flag
//  status_out  out  32  CPU-readable status word
//  txd         out  1   serial output, idle high
//  busy        out  1   1 while a frame is on the line (FSM not IDLE)
//  fifo_full   out  1   FIFO holds 2**FIFO_AW entries
//  fifo_empty  out  1   FIFO holds 0 entries
// BEHAVIOUR
//  Reset (async, RSTN=0): txd=1, busy=0, fifo_full=0, fifo_empty=1, overflow=0, count=0,
//    FSM=IDLE, baud counter=0, FIFO pointers=0. Mid-frame reset aborts the frame; txd=1 immediately.
//  Write: uart_we=1 and uart_data[8]=0 -> push uart_data[7:0]; count visible next cycle.
//  Control write: uart_we=1 and uart_data[8]=1 -> clear sticky overflow; nothing pushed.
//  Push when full -> byte dropped, overflow set (sticky); FIFO contents unchanged.
//  Push and pop in the same cycle while full -> both take effect; count unchanged; no overflow.
//  Push and pop in the same cycle while empty -> impossible (pop requires non-empty); push only.
//  FIFO pointers wrap modulo 2**FIFO_AW; count is FIFO_AW+1 bits wide, range 0..2**FIFO_AW.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE:   txd=1. If FIFO non-empty: pop head into shift reg, baud cnt=0, go to START.
//   START:  txd=0 for BAUD_DIV cycles.
//   DATA:   txd=shift[0], LSB first. After each BAUD_DIV cycles shift right; 8 bits.
//   PARITY: txd=^byte (even parity), BAUD_DIV cycles (only with UART_PARITY_EN).
//   STOP:   txd=1 for BAUD_DIV cycles. Then IDLE, or START directly if FIFO non-empty
//           (back-to-back frames, no idle gap).
//  Baud counter counts 0..BAUD_DIV-1. The bit advances on the cycle the counter = BAUD_DIV-1.
//  Latency: write at edge N into an empty FIFO while IDLE -> pop at edge N+1 -> txd=0 from edge N+2.
//  Frame length: 10*BAUD_DIV cycles (11*BAUD_DIV with parity).
//  busy=1 in START/DATA/PARITY/STOP. txd is a registered output (glitch-free).
//  status_out: [0] busy, [1] fifo_full, [2] fifo_empty, [3] overflow,
//    [4+FIFO_AW:4] count, remaining bits 0. Combinational from registers.
// CONFIGURATION
//  UART_PARITY_EN defined: PARITY state present; frame = start + 8 data + even parity + stop.
//  UART_PARITY_EN undefined: PARITY state and logic absent; frame = 8N1.
//  Status word layout and the FIFO are identical in both builds.
// TESTING (BAUD_DIV=4, FIFO_AW=2 unless noted)
//  1 Reset: RSTN=0 -> txd=1, status_out=32'h0000_0004; release RSTN, 10 cycles idle -> unchanged.
//  2 Single byte: write 32'h55 -> txd=0 two edges later.
//    Then txd = 1,0,1,0,1,0,1,0 in 4-cycle bits, stop=1; busy high exactly 40 cycles.
//  3 Overflow: 5 writes in consecutive cycles (0x01..0x05) -> 0x01 popped, 0x02..0x05 queued, no overflow.
//    A 6th write while full -> overflow=1, status[3]=1.
//    Control write 32'h100 -> status[3]=0.
//    Line carries 01,02,03,04,05 back-to-back with no idle gap.
//  4 Full + simultaneous pop: fill FIFO, then write on the cycle STOP ends -> accepted, overflow stays 0.
//  5 Reset mid-frame: RSTN=0 during DATA bit 3 of 0xA5 -> txd=1 at once.
//    After release, status_out=32'h4 and no further frame is sent.
//  6 UART_PARITY_EN build: write 0x07 -> parity bit=1, frame 44 cycles.
//    Write 0x03 -> parity bit=0.

Source files
------------

// File: rtl/uart_tx_periph_if.sv
// Bus-side bundle of the UART transmitter: write strobe/data in, status and line out.
// master = bus decoder side, slave = uart_tx_periph.
interface uart_tx_periph_if;
    logic        uart_we;
    logic [31:0] uart_data;
    logic [31:0] status_out;
    logic        txd;
    logic        busy;
    logic        fifo_full;
    logic        fifo_empty;

    modport master (
        output uart_we, uart_data,
        input  status_out, txd, busy, fifo_full, fifo_empty
    );

    modport slave (
        input  uart_we, uart_data,
        output status_out, txd, busy, fifo_full, fifo_empty
    );
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: byte FIFO fed by bus writes, 8N1 serialiser, status word.
// Ports: clk, RSTN (async low), bus (uart_we, uart_data in; status_out, txd, busy, fifo_full,
// fifo_empty out). Define UART_PARITY_EN to add an even parity bit before the stop bit.
module uart_tx_periph #(
    parameter int BAUD_DIV = 868,
    parameter int FIFO_AW  = 4
) (
    input  logic clk,
    input  logic RSTN,
    uart_tx_periph_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    state_t           state_q;
    logic [BW-1:0]    baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             txd_q;
`ifdef UART_PARITY_EN
    logic             par_q;
`endif

    logic full, empty, last_tick, pop, push_req, ctrl_wr, push;
    logic [7:0] head;

    always_comb begin
        full      = (cnt_q == (FIFO_AW+1)'(DEPTH));
        empty     = (cnt_q == '0);
        last_tick = (baud_q == BW'(BAUD_DIV - 1));
        head      = mem_q[rptr_q];
        // Pop in IDLE, or at the end of STOP for back-to-back frames.
        pop       = !empty &&
                    ((state_q == IDLE) || ((state_q == STOP) && last_tick));
        push_req  = bus.uart_we && !bus.uart_data[8];
        ctrl_wr   = bus.uart_we &&  bus.uart_data[8];
        // A full FIFO still accepts a byte when the head leaves this cycle.
        push      = push_req && (!full || pop);

        wptr_d = push ? wptr_q + FIFO_AW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + FIFO_AW'(1) : rptr_q;

        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + (FIFO_AW+1)'(1);
        else if (pop && !push)
            cnt_d = cnt_q - (FIFO_AW+1)'(1);

        ovf_d = ovf_q;
        if (ctrl_wr)
            ovf_d = 1'b0;
        else if (push_req && !push)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= bus.uart_data[7:0];
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            // Line level follows the state one cycle later, from a flop.
            case (state_q)
                START:   txd_q <= 1'b0;
                DATA:    txd_q <= shift_q[0];
`ifdef UART_PARITY_EN
                PARITY:  txd_q <= par_q;
`endif
                default: txd_q <= 1'b1;
            endcase

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q <= head;
`ifdef UART_PARITY_EN
                        par_q   <= ^head;
`endif
                        baud_q  <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (last_tick) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (last_tick) begin
                        baud_q  <= '0;
                        state_q <= STOP;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`endif
                STOP: begin
                    if (last_tick) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= head;
`ifdef UART_PARITY_EN
                            par_q   <= ^head;
`endif
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.txd        = txd_q;
        bus.busy       = (state_q != IDLE);
        bus.fifo_full  = full;
        bus.fifo_empty = empty;
        bus.status_out = '0;
        bus.status_out[0] = (state_q != IDLE);
        bus.status_out[1] = full;
        bus.status_out[2] = empty;
        bus.status_out[3] = ovf_q;
        bus.status_out[4+FIFO_AW:4] = cnt_q;
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Randomised scoreboard bench for uart_tx_periph: a line receiver decodes frames from txd
// and compares them with bytes queued at write time; directed checks cover status/timing.
module tb_uart_tx_periph;
    localparam int BAUD_DIV = 4;
    localparam int FIFO_AW  = 2;
`ifdef UART_PARITY_EN
    localparam int FRAME = 11 * BAUD_DIV;
`else
    localparam int FRAME = 10 * BAUD_DIV;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b1;
    bit   rec_starts = 1'b0;

    logic [7:0] exp_q[$];
    int         starts[$];

    uart_tx_periph_if bus ();

    uart_tx_periph #(.BAUD_DIV(BAUD_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk  (clk),
        .RSTN (rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the write taken at the edge between.
    task automatic wr(input logic [31:0] d);
        bus.uart_we   = 1'b1;
        bus.uart_data = d;
        @(negedge clk);
        bus.uart_we   = 1'b0;
        bus.uart_data = '0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b);
        wr({24'h0, b});
    endtask

    // Line receiver: samples the middle of every bit.
    initial begin : monitor
        int t0;
        bit en0;
        logic [7:0] b;
        logic [7:0] e;
        logic st, sp, par;
        forever begin
            @(negedge clk);
            if (rst_n && bus.txd === 1'b0) begin
                t0  = cyc;
                en0 = mon_en;
                par = 1'b0;
                repeat (2) @(negedge clk);
                st = bus.txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD_DIV) @(negedge clk);
                    b[i] = bus.txd;
                end
`ifdef UART_PARITY_EN
                repeat (BAUD_DIV) @(negedge clk);
                par = bus.txd;
`endif
                repeat (BAUD_DIV) @(negedge clk);
                sp = bus.txd;
                if (en0 && mon_en) begin
                    if (rec_starts) starts.push_back(t0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %h expected none", b);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_start", {31'h0, st}, 32'h0);
                        chk("frame_data", {24'h0, b}, {24'h0, e});
`ifdef UART_PARITY_EN
                        chk("frame_parity", {31'h0, par}, {31'h0, ^e});
`endif
                        chk("frame_stop", {31'h0, sp}, 32'h1);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int zeros;
        int k;
        bus.uart_we   = 1'b0;
        bus.uart_data = '0;

        // Reset state
        @(negedge clk);
        chk("rst_txd", {31'h0, bus.txd}, 32'h1);
        chk("rst_status", bus.status_out, 32'h4);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_txd", {31'h0, bus.txd}, 32'h1);
        chk("idle_status", bus.status_out, 32'h4);

        // Single byte latency and busy length
        push_byte(8'h55);
        chk("lat_status_n", bus.status_out, 32'h10);
        @(negedge clk);
        chk("lat_txd_n1", {31'h0, bus.txd}, 32'h1);
        chk("lat_status_n1", bus.status_out, 32'h5);
        n = bus.busy ? 1 : 0;
        @(negedge clk);
        chk("lat_txd_n2", {31'h0, bus.txd}, 32'h0);
        while (bus.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, FRAME);
        repeat (FRAME) @(negedge clk);

        // Overflow, control clear, back-to-back frames
        starts.delete();
        rec_starts = 1'b1;
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        chk("full_status", bus.status_out, 32'h43);
        chk("full_flag", {31'h0, bus.fifo_full}, 32'h1);
        wr(32'h06);
        chk("ovf_set", bus.status_out, 32'h4B);
        wr(32'h100);
        chk("ovf_clear", bus.status_out, 32'h43);
        repeat (6 * FRAME) @(negedge clk);
        rec_starts = 1'b0;
        chk("b2b_frames", starts.size(), 5);
        for (int i = 1; i < starts.size(); i++)
            chk("b2b_gap", starts[i] - starts[i-1], FRAME);

        // Full FIFO accepts a write on the cycle the head is popped
        for (int i = 0; i < 5; i++) push_byte(8'h11 + 8'(i));
        repeat (FRAME - 4) @(negedge clk);
        chk("pre_pop_full", bus.status_out, 32'h43);
        push_byte(8'h16);
        chk("pop_push_status", bus.status_out, 32'h43);
        repeat (6 * FRAME + 10) @(negedge clk);
        chk("pop_push_drained", exp_q.size(), 0);

        // Randomised bursts
        for (int r = 0; r < 20; r++) begin
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) push_byte(8'($urandom));
            repeat (k * FRAME + 10) @(negedge clk);
        end
        chk("rand_drained", exp_q.size(), 0);

        // Reset in the middle of DATA bit 3
        mon_en = 1'b0;
        wr(32'hA5);
        repeat (19) @(negedge clk);
        chk("mid_bit3", {31'h0, bus.txd}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", {31'h0, bus.txd}, 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_status", bus.status_out, 32'h4);
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.txd !== 1'b1) zeros++;
        end
        chk("post_rst_quiet", zeros, 0);
        mon_en = 1'b1;

`ifdef UART_PARITY_EN
        push_byte(8'h07);
        repeat (FRAME + 10) @(negedge clk);
        push_byte(8'h03);
        repeat (FRAME + 10) @(negedge clk);
`endif

        repeat (20) @(negedge clk);
        chk("final_status", bus.status_out, 32'h4);
        chk("final_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
